// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and address-field width helpers for the data cache
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } cache_state_t;

  localparam int WORD_BITS = 32;
  localparam int BYTE_BITS = 2;

  function automatic int offset_width(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int index_width(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_width(input int lines, input int words_per_line);
    return WORD_BITS - BYTE_BITS - offset_width(words_per_line) - index_width(lines);
  endfunction

endpackage

// File: rtl/cache_data_array.sv
// rtl/cache_data_array.sv - line/word data storage, asynchronous read, single-word synchronous write
module cache_data_array
  import cache_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int LINE_W         = index_width(LINES),
  parameter int WORD_W         = offset_width(WORDS_PER_LINE)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [LINE_W-1:0]    line_sel,
  input  logic [WORD_W-1:0]    wr_word,
  input  logic [WORD_BITS-1:0] wdata,
  input  logic [WORD_W-1:0]    rd_word,
  output logic [WORD_BITS-1:0] rdata
);

  logic [WORD_BITS-1:0] mem [LINES*WORDS_PER_LINE];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[{line_sel, wr_word}] <= wdata;
    end
  end

  assign rdata = mem[{line_sel, rd_word}];

endmodule

// File: rtl/dcache_direct_mapped.sv
// rtl/dcache_direct_mapped.sv - blocking direct-mapped write-through, no-write-allocate data cache
module dcache_direct_mapped
  import cache_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        d_ready,
  output logic        d_hit,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int OB = offset_width(WORDS_PER_LINE);
  localparam int IB = index_width(LINES);
  localparam int TB = tag_width(LINES, WORDS_PER_LINE);
  localparam logic [OB-1:0] LAST_WORD = OB'(WORDS_PER_LINE - 1);

  cache_state_t state, state_next;

  logic [OB-1:0] cnt;
  logic          hit_q;
  logic [LINES-1:0] valid;
  logic [TB-1:0]    tag_mem [LINES];

  logic [TB-1:0] addr_tag;
  logic [IB-1:0] addr_index;
  logic [OB-1:0] addr_word;
  logic          hit;
  logic          last_ack;
  logic          addr_unused;

  logic        arr_we;
  logic [OB-1:0] arr_word;
  logic [31:0] arr_wdata;
  logic [31:0] arr_rdata;

  assign addr_tag    = addr[31 -: TB];
  assign addr_index  = addr[BYTE_BITS+OB +: IB];
  assign addr_word   = addr[BYTE_BITS +: OB];
  assign addr_unused = ^addr[1:0];
  assign hit         = valid[addr_index] && (tag_mem[addr_index] == addr_tag);
  assign last_ack    = (state == REFILL) && mem_ack && (cnt == LAST_WORD);

  cache_data_array #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_data (
    .clk      (clk),
    .we       (arr_we),
    .line_sel (addr_index),
    .wr_word  (arr_word),
    .wdata    (arr_wdata),
    .rd_word  (addr_word),
    .rdata    (arr_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      hit_q <= 1'b0;
      valid <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (d_write) begin
            hit_q <= hit;
          end else if (d_read && !hit) begin
            hit_q <= 1'b0;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            cnt <= cnt + OB'(1);
          end
          if (last_ack) begin
            valid[addr_index] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Tags are only meaningful behind a set valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    if (last_ack) begin
      tag_mem[addr_index] <= addr_tag;
    end
  end

  always_comb begin
    state_next = state;
    d_ready    = 1'b0;
    d_hit      = 1'b0;
    rdata      = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    arr_we     = 1'b0;
    arr_word   = cnt;
    arr_wdata  = mem_rdata;
    case (state)
      IDLE: begin
        if (d_write) begin
          state_next = WRITE;
        end else if (d_read) begin
          if (hit) begin
            d_ready = 1'b1;
            d_hit   = 1'b1;
            rdata   = arr_rdata;
          end else begin
            state_next = REFILL;
          end
        end else begin
          d_ready = 1'b1;
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {addr_tag, addr_index, cnt, 2'b00};
        if (mem_ack) begin
          arr_we = 1'b1;
          if (cnt == LAST_WORD) begin
            state_next = DONE;
          end
        end
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {addr[31:2], 2'b00};
        mem_wdata = wdata;
        if (mem_ack) begin
          // Write-through keeps a hit line coherent; a miss leaves the array alone.
          arr_we     = hit_q;
          arr_word   = addr_word;
          arr_wdata  = wdata;
          state_next = DONE;
        end
      end
      DONE: begin
        d_ready    = 1'b1;
        d_hit      = hit_q;
        rdata      = arr_rdata;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// tb/tb_dcache_direct_mapped.sv - directed self-checking bench for dcache_direct_mapped
module tb_dcache_direct_mapped;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_read, d_write;
  logic [31:0] addr, wdata, rdata;
  logic        d_ready, d_hit;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_model [4096];
  logic [31:0] rd_log[$];
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          req_cycles = 0;
  int          stable_err = 0;
  logic        in_req = 1'b0;
  logic [31:0] f_addr, f_wdata;
  logic        f_we;

  int          cyc;
  logic        hit;
  logic [31:0] rval;

  dcache_direct_mapped dut (
    .clk       (clk),
    .reset     (reset),
    .d_read    (d_read),
    .d_write   (d_write),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .d_ready   (d_ready),
    .d_hit     (d_hit),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  // Memory responder: acks after ack_delay wait cycles, logs traffic, checks request stability.
  always @(negedge clk) begin
    if (!reset) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
      in_req   = 1'b0;
    end else begin
      mem_ack = 1'b0;
      if (mem_req) begin
        req_cycles++;
        if (!in_req) begin
          in_req  = 1'b1;
          f_addr  = mem_addr;
          f_we    = mem_we;
          f_wdata = mem_wdata;
        end else if (mem_addr !== f_addr || mem_we !== f_we || mem_wdata !== f_wdata) begin
          stable_err++;
        end
        if (wait_cnt == ack_delay) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
          in_req   = 1'b0;
          if (mem_we) begin
            mem_model[mem_addr[13:2]] = mem_wdata;
            wr_addr_log.push_back(mem_addr);
            wr_data_log.push_back(mem_wdata);
          end else begin
            mem_rdata = mem_model[mem_addr[13:2]];
            rd_log.push_back(mem_addr);
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        in_req   = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    rd_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    req_cycles = 0;
    stable_err = 0;
  endtask

  // Presents one access and counts cycles inclusive of the one where d_ready is seen.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, output int n, output logic h,
                           output logic [31:0] v);
    logic done;
    done = 1'b0;
    n = 0;
    h = 1'b0;
    v = '0;
    @(posedge clk);
    #1;
    d_read  = rd;
    d_write = wr;
    addr    = a;
    wdata   = d;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      if (d_ready) begin
        done = 1'b1;
        h    = d_hit;
        v    = rdata;
      end
    end
    check("access_completes", {31'd0, done}, 32'd1);
    @(posedge clk);
    #1;
    d_read  = 1'b0;
    d_write = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem_model[i] = 32'hC0DE_0000 | i;
    reset = 1'b0;
    d_read = 1'b0;
    d_write = 1'b0;
    addr = '0;
    wdata = '0;
    mem_rdata = '0;
    mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_d_ready", {31'd0, d_ready}, 32'd1);
    check("rst_d_hit", {31'd0, d_hit}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Cold read miss with ack every cycle
    clear_logs();
    do_access(1'b1, 1'b0, 32'h40, 32'h0, cyc, hit, rval);
    check("miss_cycles", cyc, 32'd6);
    check("miss_hit", {31'd0, hit}, 32'd0);
    check("miss_rdata", rval, 32'hC0DE_0010);
    check("miss_nreads", rd_log.size(), 32'd4);
    check("miss_rd0", rd_log[0], 32'h40);
    check("miss_rd1", rd_log[1], 32'h44);
    check("miss_rd2", rd_log[2], 32'h48);
    check("miss_rd3", rd_log[3], 32'h4C);

    // Read hit in the same line
    clear_logs();
    do_access(1'b1, 1'b0, 32'h44, 32'h0, cyc, hit, rval);
    check("hit_cycles", cyc, 32'd1);
    check("hit_hit", {31'd0, hit}, 32'd1);
    check("hit_rdata", rval, 32'hC0DE_0011);
    check("hit_no_req", req_cycles, 32'd0);

    // Write hit with ack delayed 3 cycles
    clear_logs();
    ack_delay = 3;
    do_access(1'b0, 1'b1, 32'h48, 32'hDEAD_BEEF, cyc, hit, rval);
    ack_delay = 0;
    check("wrhit_cycles", cyc, 32'd6);
    check("wrhit_hit", {31'd0, hit}, 32'd1);
    check("wrhit_nwr", wr_addr_log.size(), 32'd1);
    check("wrhit_addr", wr_addr_log[0], 32'h48);
    check("wrhit_data", wr_data_log[0], 32'hDEAD_BEEF);
    check("wrhit_stable", stable_err, 32'd0);
    check("wrhit_req_cycles", req_cycles, 32'd4);
    do_access(1'b1, 1'b0, 32'h48, 32'h0, cyc, hit, rval);
    check("rd48_hit", {31'd0, hit}, 32'd1);
    check("rd48_rdata", rval, 32'hDEAD_BEEF);

    // Read and write together act as a write
    clear_logs();
    do_access(1'b1, 1'b1, 32'h44, 32'h55AA_55AA, cyc, hit, rval);
    check("rw_cycles", cyc, 32'd3);
    check("rw_hit", {31'd0, hit}, 32'd1);
    check("rw_nwr", wr_addr_log.size(), 32'd1);
    check("rw_nrd", rd_log.size(), 32'd0);
    do_access(1'b1, 1'b0, 32'h44, 32'h0, cyc, hit, rval);
    check("rd44_rdata", rval, 32'h55AA_55AA);

    // Write miss: no allocation
    clear_logs();
    do_access(1'b0, 1'b1, 32'h1000, 32'h1234_5678, cyc, hit, rval);
    check("wrmiss_cycles", cyc, 32'd3);
    check("wrmiss_hit", {31'd0, hit}, 32'd0);
    check("wrmiss_addr", wr_addr_log[0], 32'h1000);
    clear_logs();
    do_access(1'b1, 1'b0, 32'h1000, 32'h0, cyc, hit, rval);
    check("rd1000_hit", {31'd0, hit}, 32'd0);
    check("rd1000_cycles", cyc, 32'd6);
    check("rd1000_rdata", rval, 32'h1234_5678);
    check("rd1000_nreads", rd_log.size(), 32'd4);
    do_access(1'b1, 1'b0, 32'h1000, 32'h0, cyc, hit, rval);
    check("rd1000_again_hit", {31'd0, hit}, 32'd1);

    // Conflict on index 4
    do_access(1'b1, 1'b0, 32'h40, 32'h0, cyc, hit, rval);
    check("conf_40_hit", {31'd0, hit}, 32'd1);
    do_access(1'b1, 1'b0, 32'h140, 32'h0, cyc, hit, rval);
    check("conf_140_hit", {31'd0, hit}, 32'd0);
    check("conf_140_rdata", rval, 32'hC0DE_0050);
    do_access(1'b1, 1'b0, 32'h40, 32'h0, cyc, hit, rval);
    check("conf_40_again_hit", {31'd0, hit}, 32'd0);
    check("conf_40_again_rdata", rval, 32'hC0DE_0010);

    // Reset after two refill words
    clear_logs();
    @(posedge clk);
    #1;
    d_read = 1'b1;
    addr   = 32'h80;
    repeat (3) @(posedge clk);
    #3;
    check("pre_rst_mem_req", {31'd0, mem_req}, 32'd1);
    reset = 1'b0;
    #1;
    check("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("async_rst_mem_addr", mem_addr, 32'd0);
    check("abort_nreads", rd_log.size(), 32'd2);
    d_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    clear_logs();
    do_access(1'b1, 1'b0, 32'h80, 32'h0, cyc, hit, rval);
    check("post_rst_hit", {31'd0, hit}, 32'd0);
    check("post_rst_cycles", cyc, 32'd6);
    check("post_rst_rdata", rval, 32'hC0DE_0020);
    check("post_rst_nreads", rd_log.size(), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_direct_mapped.md
# dcache_direct_mapped

Blocking, direct-mapped, write-through / no-write-allocate data cache placed between the pipeline's memory stage and main data memory. It produces the `d_ready`/`d_hit` event stream consumed by the cache monitor and stalls the pipeline on misses. Read misses refill a full line through a simple req/ack memory handshake.

## Interface
- `LINES`, 16: number of cache lines; power of 2, at least 2.
- `WORDS_PER_LINE`, 4: 32-bit words per line; power of 2, at least 2.
- `clk  in  1`: single clock. All state changes on its rising edge.
- `reset  in  1`: asynchronous, active-low reset.
- `d_read  in  1`: CPU load request. Held stable until `d_ready`.
- `d_write  in  1`: CPU store request. Held stable until `d_ready`.
- `addr  in  32`: CPU byte address. Bits [1:0] are ignored.
- `wdata  in  32`: store data.
- `rdata  out  32`: load data. Valid only when `d_ready` is 1 for a read.
- `d_ready  out  1`: access complete, or no access pending. 0 stalls the pipeline.
- `d_hit  out  1`: asserted with `d_ready` when the completing access hit.
- `mem_req  out  1`: memory request. Held until `mem_ack`.
- `mem_we  out  1`: 1 = memory write, 0 = memory read.
- `mem_addr  out  32`: word-aligned memory address.
- `mem_wdata  out  32`: memory write data.
- `mem_rdata  in  32`: memory read data. Sampled in the `mem_ack` cycle.
- `mem_ack  in  1`: one-cycle completion pulse from memory.

## Operation
- Address fields, from LSB: byte [1:0], word offset (log2 `WORDS_PER_LINE` bits), index (log2 `LINES` bits), tag (remaining bits). With defaults: word [3:2], index [7:4], tag [31:8].
- Per-line storage: valid bit, tag, and `WORDS_PER_LINE` data words.
- Hit condition: `valid[index]` and the stored tag equals the address tag.
- States:
  - **IDLE**: accepts requests.
    - Read hit: `d_ready`=1, `d_hit`=1, `rdata` from the array, combinationally. The state stays IDLE.
    - Read miss: go to REFILL with word counter = 0.
    - Write, hit or miss: go to WRITE and latch whether it hit.
    - No request: `d_ready`=1, `d_hit`=0.
  - **REFILL**: drive `mem_req`=1, `mem_we`=0, `mem_addr` = {tag, index, counter, 2'b00}.
    - On each `mem_ack`, store `mem_rdata` into the word slot and increment the counter.
    - On the ack for the last word, write the tag, set valid, and go to DONE.
  - **WRITE**: drive `mem_req`=1, `mem_we`=1, `mem_addr` = {addr[31:2], 2'b00}, `mem_wdata` = `wdata`.
    - On `mem_ack`: if the latched result was a hit, update the cached word. Go to DONE.
    - A write miss never allocates a line.
  - **DONE**: one cycle only.
    - `d_ready`=1; `d_hit` = latched hit flag (always 0 after a refill).
    - `rdata` = the array word at `addr`.
    - Return to IDLE.
- `d_read` and `d_write` both high: treated as a write.
- `mem_ack` outside REFILL/WRITE is ignored. `mem_rdata` is don't-care outside the ack cycle.
- `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` are constant while `mem_req` is high.

## Timing
- Reset, asynchronous on `reset`=0:
  - All valid bits 0, state IDLE, counter 0, hit flag 0.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `d_ready`=1, `d_hit`=0, `rdata`=0.
- Reset during REFILL or WRITE: the transaction is abandoned, `mem_req` drops immediately, and no partial line becomes valid. Memory must tolerate a dropped request.
- Read hit latency: 0 extra cycles; `d_ready` in the request cycle.
- Read miss latency:
  - Best case (ack every cycle): `d_ready` rises 2 + `WORDS_PER_LINE` cycles after the request appears (1 IDLE cycle, `WORDS_PER_LINE` REFILL cycles, then DONE).
  - In general: that plus all memory wait cycles.
- Write latency: `d_ready` rises in the cycle after the write `mem_ack`. Best case is 3 cycles after the request appears.
- Back-to-back accesses: a new request is evaluated in the cycle after DONE (IDLE).
- The pipeline advances on `d_ready`, so each access completes exactly once.

## Structure
- Package `cache_pkg`:
  - `cache_state_t` enum: IDLE, REFILL, WRITE, DONE.
  - Localparams/functions for offset, index and tag widths derived from `LINES` and `WORDS_PER_LINE`.
- Sub-module `cache_data_array`: LINES × WORDS_PER_LINE × 32 registers, asynchronous read, synchronous single-word write.
- Valid and tag storage plus the FSM stay in the top block.

## Test plan
- Reset, then read 0x40 with `mem_ack` every cycle:
  - Four memory reads, at 0x40, 0x44, 0x48, 0x4C.
  - `d_ready` rises 6 cycles after the request appears, with `d_hit`=0 and `rdata` = memory[0x40].
- Read 0x44 immediately after that miss: same-cycle `d_ready`=1, `d_hit`=1, `rdata` = memory[0x44], no `mem_req`.
- Write 0xDEADBEEF to 0x48 (hit):
  - One memory write with `mem_we`=1 and the data unchanged while `mem_ack` is delayed 3 cycles.
  - DONE has `d_hit`=1.
  - A following read of 0x48 hits and returns 0xDEADBEEF.
- Write to 0x1000 (miss):
  - Memory write issued; DONE has `d_hit`=0.
  - A following read of 0x1000 misses and refills.
- Conflict: read 0x40, then read 0x140 (same index, new tag) → second read misses. Re-reading 0x40 misses again.
- Assert `reset`=0 after 2 words of a refill:
  - `mem_req` drops asynchronously.
  - After release, a read of that line misses.
